// File: rtl/mips_exec_ctrl_if.sv
// Bus between the host-facing command sequencer and the UART byte layer / MIPS core.
// slave: the sequencer itself; master: the UART, core and debug-bus side.
interface mips_exec_ctrl_if #(
   parameter int ADDR_W     = 8,
   parameter int DUMP_BYTES = 320
);
   logic [7:0]              i_rx_byte;
   logic                    is_rx_done;
   logic                    is_tx_done;
   logic                    i_stop_pipe;
   logic [DUMP_BYTES*8-1:0] i_dump_data;
   logic [7:0]              o_tx_byte;
   logic                    os_tx_start;
   logic                    os_step;
   logic                    os_MemWrite;
   logic [ADDR_W-1:0]       o_address;
   logic [31:0]             o_instruction;
   logic                    o_led;

   // Handshakes: is_rx_done and is_tx_done are single-cycle pulses. os_tx_start is a
   // single-cycle pulse, and o_tx_byte stays valid until is_tx_done comes back.
   modport slave (
      input  i_rx_byte, is_rx_done, is_tx_done, i_stop_pipe, i_dump_data,
      output o_tx_byte, os_tx_start, os_step, os_MemWrite, o_address, o_instruction, o_led
   );

   modport master (
      output i_rx_byte, is_rx_done, is_tx_done, i_stop_pipe, i_dump_data,
      input  o_tx_byte, os_tx_start, os_step, os_MemWrite, o_address, o_instruction, o_led
   );
endinterface

// File: rtl/mips_exec_ctrl.sv
// Host command sequencer for the MIPS core. It loads program memory, runs or steps
// the pipeline, and streams the debug bus back over the UART one byte at a time.
module mips_exec_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DUMP_BYTES = 320,
   parameter int RUN_LIMIT  = 65535
) (
   input  logic              clk,
   input  logic              rst,
   mips_exec_ctrl_if.slave   io_bus,
   output logic [2:0]        o_dbg_state
);
   localparam int IDX_W = $clog2(DUMP_BYTES);
   localparam int RUN_W = $clog2(RUN_LIMIT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_BYTES - 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LIMIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_CNT, S_LOAD_DATA, S_RUN, S_STEP, S_STEP_WAIT, S_DUMP_SEND, S_DUMP_WAIT
   } state_t;

   state_t            r_state;
   logic              r_step;
   logic              r_mem_write;
   logic              r_led;
   logic              r_tx_start;
   logic [7:0]        r_tx_byte;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_instr;
   logic [8:0]        r_word_cnt;
   logic [1:0]        r_byte_cnt;
   logic [IDX_W-1:0]  r_dump_idx;
   logic [RUN_W-1:0]  r_run_cnt;
   logic              w_last_word;

   // The word whose write strobe is asserted this cycle is the last one of the load.
   assign w_last_word = r_mem_write && (r_word_cnt == 9'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_step      <= 1'b0;
         r_mem_write <= 1'b0;
         r_led       <= 1'b0;
         r_tx_start  <= 1'b0;
         r_tx_byte   <= '0;
         r_addr      <= '0;
         r_instr     <= '0;
         r_word_cnt  <= '0;
         r_byte_cnt  <= '0;
         r_dump_idx  <= '0;
         r_run_cnt   <= '0;
      end else begin
         r_tx_start  <= 1'b0;
         r_mem_write <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_bus.is_rx_done) begin
                  case (io_bus.i_rx_byte)
                     8'h01: r_state <= S_LOAD_CNT;
                     8'h02: if (!r_led) begin
                        r_state   <= S_RUN;
                        r_step    <= 1'b1;
                        r_run_cnt <= '0;
                     end
                     8'h03: if (!r_led) begin
                        r_state <= S_STEP;
                        r_step  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            S_LOAD_CNT: begin
               if (io_bus.is_rx_done) begin
                  r_word_cnt <= (io_bus.i_rx_byte == 8'h00) ? 9'd256 : {1'b0, io_bus.i_rx_byte};
                  r_led      <= 1'b0;
                  r_addr     <= '0;
                  r_byte_cnt <= '0;
                  r_state    <= S_LOAD_DATA;
               end
            end
            S_LOAD_DATA: begin
               if (r_mem_write) begin
                  r_addr     <= r_addr + 1'b1;
                  r_word_cnt <= r_word_cnt - 1'b1;
                  if (w_last_word) r_state <= S_IDLE;
               end
               if (io_bus.is_rx_done && !w_last_word) begin
                  r_instr    <= {r_instr[23:0], io_bus.i_rx_byte};
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                  if (r_byte_cnt == 2'd3) r_mem_write <= 1'b1;
               end
            end
            S_RUN: begin
               r_run_cnt <= r_run_cnt + 1'b1;
               if (io_bus.i_stop_pipe) begin
                  r_step  <= 1'b0;
                  r_led   <= 1'b1;
                  r_state <= S_DUMP_SEND;
               end else if (r_run_cnt == RUN_LAST) begin
                  r_step  <= 1'b0;
                  r_state <= S_DUMP_SEND;
               end
            end
            S_STEP: begin
               r_step  <= 1'b0;
               r_state <= S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
               if (io_bus.i_stop_pipe) r_led <= 1'b1;
               r_state <= S_DUMP_SEND;
            end
            S_DUMP_SEND: begin
               r_tx_byte  <= io_bus.i_dump_data[{r_dump_idx, 3'b000} +: 8];
               r_tx_start <= 1'b1;
               r_state    <= S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
               if (io_bus.is_tx_done) begin
                  if (r_dump_idx == LAST_IDX) begin
                     r_dump_idx <= '0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_dump_idx <= r_dump_idx + 1'b1;
                     r_state    <= S_DUMP_SEND;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.o_tx_byte     = r_tx_byte;
   assign io_bus.os_tx_start   = r_tx_start;
   assign io_bus.os_step       = r_step;
   assign io_bus.os_MemWrite   = r_mem_write;
   assign io_bus.o_address     = r_addr;
   assign io_bus.o_instruction = r_instr;
   assign io_bus.o_led         = r_led;
   assign o_dbg_state          = r_state;
endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Bench for mips_exec_ctrl: u_dut0 uses the default run limit, u_dut1 a run limit of 16.
// sel routes the stimulus to one DUT and picks which DUT's outputs are observed.
module tb_mips_exec_ctrl;
   localparam int DB = 320;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            sel;
   logic [7:0]      rx_byte;
   logic            rx_done, tx_done, stop;
   logic [DB*8-1:0] dump_data;
   logic [2:0]      dbg0, dbg1;

   mips_exec_ctrl_if #(.ADDR_W(8), .DUMP_BYTES(DB)) u_if0 ();
   mips_exec_ctrl_if #(.ADDR_W(8), .DUMP_BYTES(DB)) u_if1 ();

   assign u_if0.i_rx_byte   = rx_byte;
   assign u_if0.is_rx_done  = rx_done & ~sel;
   assign u_if0.is_tx_done  = tx_done & ~sel;
   assign u_if0.i_stop_pipe = stop;
   assign u_if0.i_dump_data = dump_data;
   assign u_if1.i_rx_byte   = rx_byte;
   assign u_if1.is_rx_done  = rx_done & sel;
   assign u_if1.is_tx_done  = tx_done & sel;
   assign u_if1.i_stop_pipe = stop;
   assign u_if1.i_dump_data = dump_data;

   mips_exec_ctrl #(.ADDR_W(8), .DUMP_BYTES(DB)) u_dut0 (
      .clk(clk), .rst(rst), .io_bus(u_if0.slave), .o_dbg_state(dbg0));
   mips_exec_ctrl #(.ADDR_W(8), .DUMP_BYTES(DB), .RUN_LIMIT(16)) u_dut1 (
      .clk(clk), .rst(rst), .io_bus(u_if1.slave), .o_dbg_state(dbg1));

   logic        w_step, w_mw, w_tx_start, w_led;
   logic [7:0]  w_tx_byte, w_addr;
   logic [31:0] w_instr;
   logic [2:0]  w_state;
   assign w_step     = sel ? u_if1.os_step       : u_if0.os_step;
   assign w_mw       = sel ? u_if1.os_MemWrite   : u_if0.os_MemWrite;
   assign w_tx_start = sel ? u_if1.os_tx_start   : u_if0.os_tx_start;
   assign w_led      = sel ? u_if1.o_led         : u_if0.o_led;
   assign w_tx_byte  = sel ? u_if1.o_tx_byte     : u_if0.o_tx_byte;
   assign w_addr     = sel ? u_if1.o_address     : u_if0.o_address;
   assign w_instr    = sel ? u_if1.o_instruction : u_if0.o_instruction;
   assign w_state    = sel ? dbg1 : dbg0;

   int          total = 0;
   int          bad = 0;
   int          step_cnt = 0;
   int          tx_cnt = 0;
   logic [39:0] got_q[$];
   logic [39:0] exp_q[$];
   logic [7:0]  stim_q[$];
   logic        model_led;

   // Monitor: count step cycles and tx pulses, and collect memory writes.
   always @(negedge clk) begin
      if (w_step) step_cnt++;
      if (w_tx_start) tx_cnt++;
      if (w_mw) got_q.push_back({w_addr, w_instr});
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic new_dump();
      for (int i = 0; i < DB / 4; i++) dump_data[32*i +: 32] = $urandom();
   endtask

   // Expected writes come straight from the byte stream: count byte, then 4 bytes per word.
   task automatic do_load();
      int n;
      int base_step;
      logic [31:0] w;
      exp_q.delete();
      got_q.delete();
      n = (stim_q[1] == 8'h00) ? 256 : int'(stim_q[1]);
      for (int i = 0; i < n; i++) begin
         w = {stim_q[2+4*i], stim_q[3+4*i], stim_q[4+4*i], stim_q[5+4*i]};
         exp_q.push_back({8'(i), w});
      end
      base_step = step_cnt;
      foreach (stim_q[i]) send_byte(stim_q[i]);
      settle(4);
      model_led = 1'b0;
      check_eq("wr_count", got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) check_eq("wr_word", got_q.pop_front(), exp_q.pop_front());
      check_eq("load_no_step", step_cnt - base_step, 0);
      check_eq("load_idle", w_state, 0);
      check_eq("load_led", w_led, model_led);
   endtask

   // Acts as the transmitter. With inject set, a 0x03 byte arrives in the middle of the dump.
   task automatic serve_dump(input bit inject);
      int t;
      int miss;
      logic [7:0] exp_b;
      miss = 0;
      for (int k = 0; k < DB; k++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!w_tx_start && t < 64);
         if (!w_tx_start) begin
            check_eq("dump_timeout", k, DB);
            return;
         end
         exp_b = dump_data[8*k +: 8];
         if (k == 0 || k == 1 || k == DB - 1) check_eq($sformatf("dump_b%0d", k), w_tx_byte, exp_b);
         else if (w_tx_byte !== exp_b) miss++;
         if (inject && k == 5) begin
            rx_byte = 8'h03;
            rx_done = 1'b1;
            @(negedge clk);
            rx_done = 1'b0;
         end
         repeat ($urandom_range(1, 4)) @(negedge clk);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
      end
      check_eq("dump_rest", miss, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int base_s, base_t, t, n;
      sel = 1'b0; rx_byte = '0; rx_done = 1'b0; tx_done = 1'b0; stop = 1'b0;
      dump_data = '0; model_led = 1'b0;
      rst = 1'b1;
      settle(3);
      check_eq("rst_step", w_step, 0);
      check_eq("rst_mw", w_mw, 0);
      check_eq("rst_led", w_led, 0);
      check_eq("rst_state", w_state, 0);
      @(negedge clk);
      rst = 1'b0;
      settle(2);

      stim_q = '{8'h01, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      do_load();

      stim_q = '{8'h01};
      n = $urandom_range(1, 6);
      stim_q.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
      do_load();

      base_s = step_cnt; base_t = tx_cnt;
      send_byte(8'h7F);
      settle(4);
      check_eq("garbage_state", w_state, 0);
      check_eq("garbage_step", step_cnt - base_s, 0);
      check_eq("garbage_tx", tx_cnt - base_t, 0);

      new_dump();
      base_s = step_cnt; base_t = tx_cnt;
      send_byte(8'h03);
      serve_dump(1'b1);
      settle(10);
      check_eq("step_cycles", step_cnt - base_s, 1);
      check_eq("step_tx_pulses", tx_cnt - base_t, DB);
      check_eq("step_led", w_led, model_led);
      check_eq("step_idle", w_state, 0);

      new_dump();
      base_s = step_cnt; base_t = tx_cnt;
      send_byte(8'h02);
      t = 0;
      while (step_cnt - base_s < 37 && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      check_eq("halt_reach37", step_cnt - base_s, 37);
      stop = 1'b1;
      model_led = 1'b1;
      serve_dump(1'b0);
      stop = 1'b0;
      settle(10);
      check_eq("halt_steps", step_cnt - base_s, 37);
      check_eq("halt_tx_pulses", tx_cnt - base_t, DB);
      check_eq("halt_led", w_led, model_led);
      base_s = step_cnt; base_t = tx_cnt;
      send_byte(8'h02);
      send_byte(8'h03);
      settle(20);
      check_eq("halted_no_step", step_cnt - base_s, 0);
      check_eq("halted_no_tx", tx_cnt - base_t, 0);
      check_eq("halted_led", w_led, 1);

      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_state", w_state, 0);
      check_eq("arst_led", w_led, 0);
      check_eq("arst_instr", w_instr, 0);
      check_eq("arst_addr", w_addr, 0);
      check_eq("arst_step", w_step, 0);
      check_eq("arst_mw", w_mw, 0);
      check_eq("arst_tx_start", w_tx_start, 0);
      check_eq("arst_tx_byte", w_tx_byte, 0);
      @(negedge clk);
      rst = 1'b0;
      model_led = 1'b0;
      stim_q = '{8'h01, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_load();

      new_dump();
      stop = 1'b1;
      model_led = 1'b1;
      base_s = step_cnt;
      send_byte(8'h03);
      serve_dump(1'b0);
      stop = 1'b0;
      settle(5);
      check_eq("step_halt_cycles", step_cnt - base_s, 1);
      check_eq("step_halt_led", w_led, model_led);

      @(negedge clk);
      sel = 1'b1;
      new_dump();
      settle(2);
      base_s = step_cnt; base_t = tx_cnt;
      send_byte(8'h02);
      serve_dump(1'b0);
      settle(10);
      check_eq("timeout_steps", step_cnt - base_s, 16);
      check_eq("timeout_tx_pulses", tx_cnt - base_t, DB);
      check_eq("timeout_led", w_led, 0);
      check_eq("timeout_idle", w_state, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mips_exec_ctrl.md
Name: mips_exec_ctrl

Overview:
Command sequencer between the UART byte layer and the MIPS pipeline. It decodes host command bytes, loads program memory word by word, and drives the pipeline step enable in single-step or free-run mode. When execution pauses it streams the pipeline debug bus back to the host, one byte per transmit handshake. It owns every control input of the MIPS core: step, memory write, address and instruction.

Parameters:
ADDR_W, 8, program-memory word address width
DUMP_BYTES, 320, bytes sent per dump; covers the 2558-bit debug bus zero-padded to 2560 bits
RUN_LIMIT, 65535, maximum step cycles in RUN before a forced dump

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_rx_byte  in  8  received byte; valid when is_rx_done=1
is_rx_done  in  1  one-cycle pulse, new byte received
is_tx_done  in  1  one-cycle pulse, transmitter finished the current byte
i_stop_pipe  in  1  pipeline reached halt instruction (level)
i_dump_data  in  DUMP_BYTES*8  debug bus, zero-padded; stable whenever os_step=0
o_tx_byte  out  8  byte to transmit
os_tx_start  out  1  one-cycle pulse, start transmitting o_tx_byte
os_step  out  1  pipeline advance enable
os_MemWrite  out  1  one-cycle program-memory write strobe
o_address  out  ADDR_W  program-memory word address
o_instruction  out  32  program-memory write data
o_led  out  1  halted indicator

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; word counter, byte counter, dump index and run counter 0.
- States: IDLE, LOAD_CNT, LOAD_DATA, RUN, STEP, STEP_WAIT, DUMP_SEND, DUMP_WAIT.
- IDLE: act only on is_rx_done=1. Command bytes:
  - 0x01 -> LOAD_CNT.
  - 0x02 -> RUN, only if o_led=0.
  - 0x03 -> STEP, only if o_led=0.
  - Any other byte, or 0x02/0x03 while o_led=1, is ignored; stay in IDLE.
- LOAD_CNT: next byte N = instruction count, where N=0 means 256. Clear o_led, word address and byte counter. Go to LOAD_DATA.
- LOAD_DATA: 4 bytes per word, MSB first, shifted into o_instruction.
  - The cycle after the 4th byte: os_MemWrite=1 for exactly one cycle, with o_address = current word index.
  - Address increments after the strobe. After N words, return to IDLE.
  - The address wraps at 2^ADDR_W.
- Received bytes are ignored in RUN, STEP, STEP_WAIT, DUMP_SEND and DUMP_WAIT. No buffering.
- RUN:
  - os_step is registered; it is 1 from the first RUN cycle.
  - Each step cycle increments the run counter.
  - At the edge where i_stop_pipe=1 is sampled: os_step<=0, o_led<=1, go to DUMP_SEND.
  - At the edge where the run counter reaches RUN_LIMIT: os_step<=0, o_led unchanged, go to DUMP_SEND.
  - If both events occur in the same cycle, the stop takes priority and o_led<=1.
  - The run counter clears on entry to RUN.
- STEP: os_step=1 for exactly one cycle, then STEP_WAIT.
- STEP_WAIT: one cycle with os_step=0 so the debug bus settles. Sample i_stop_pipe: if 1, o_led<=1. Then go to DUMP_SEND.
- DUMP_SEND:
  - o_tx_byte = i_dump_data[8*k+7 : 8*k], where k is the dump index starting at 0.
  - os_tx_start=1 for one cycle, then DUMP_WAIT.
- DUMP_WAIT:
  - On is_tx_done, increment k.
  - If k was DUMP_BYTES-1, clear k and go to IDLE; otherwise go to DUMP_SEND.
  - o_tx_byte holds its value until the next DUMP_SEND.
- os_step is never 1 outside RUN/STEP. os_MemWrite is never 1 outside LOAD_DATA.
- o_led stays 1 until the next 0x01 command or reset.
- Reset mid-operation aborts immediately, including during a load, RUN or dump. Program memory contents are not cleared.

Test Plan:
- Load: bytes 01,02, AA,BB,CC,DD, 11,22,33,44 -> two os_MemWrite pulses: (addr 0, 0xAABBCCDD) then (addr 1, 0x11223344); back in IDLE; no os_step.
- Step: 03 with i_stop_pipe=0 -> os_step high exactly 1 cycle; 320 os_tx_start pulses, each gated by is_tx_done; byte k equals i_dump_data[8k+7:8k] (check k=0, 1, 319); o_led=0.
- Run to halt: 02, assert i_stop_pipe after 37 step cycles -> os_step high 37 cycles, deasserts at the sampling edge; o_led=1; full 320-byte dump; later 02 and 03 ignored.
- Run timeout: RUN_LIMIT=16, i_stop_pipe held 0 -> exactly 16 step cycles, then dump; o_led=0.
- Garbage and overlap: bytes 0x7F in IDLE, and 0x03 during a dump -> ignored; no extra step or tx pulse.
- Async reset: assert rst after the 2nd byte of a word load, then send 01,01,DE,AD,BE,EF -> all outputs 0 immediately on reset; the new load writes addr 0 = 0xDEADBEEF.
